// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache miss path: optional write-back, optional line fill, then a held response.
// Each memory phase lasts LATENCY cycles; a single request is in flight and the response stalls until resp_ready.
module cache_mem_responder #(
    parameter int TAG_W   = 3,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 3,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic              req_fill,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [IDX_W-1:0]  wb_index,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [IDX_W-1:0]  fill_index,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic [7:0]        wb_count,
    output logic [7:0]        fill_count
);
    localparam int AW    = TAG_W + IDX_W;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              cap_fill;
    logic [AW-1:0]     wb_addr;
    logic [AW-1:0]     fill_addr;
    logic [DATA_W-1:0] wb_dat_q;
    logic              accept;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign accept     = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            resp_data  <= '0;
            wb_count   <= '0;
            fill_count <= '0;
            cap_fill   <= 1'b0;
            wb_addr    <= '0;
            fill_addr  <= '0;
            wb_dat_q   <= '0;
            // Backing store powers up with each word holding the low bits of its own address.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_fill  <= req_fill;
                        wb_addr   <= {wb_tag, wb_index};
                        fill_addr <= {fill_tag, fill_index};
                        wb_dat_q  <= wb_data;
                        if (req_wb)   wb_count   <= wb_count + 8'd1;
                        if (req_fill) fill_count <= fill_count + 8'd1;
                        if (!req_fill) resp_data <= '0;
                        if (req_wb) begin
                            state <= S_WB;
                            cnt   <= CW'(LATENCY - 1);
                        end else if (req_fill) begin
                            state <= S_FILL;
                            cnt   <= CW'(LATENCY - 1);
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WB: begin
                    if (cnt == '0) begin
                        mem[wb_addr] <= wb_dat_q;
                        if (cap_fill) begin
                            state <= S_FILL;
                            cnt   <= CW'(LATENCY - 1);
                        end else begin
                            state <= S_RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FILL: begin
                    // The write-back phase has already committed, so a same-address fill sees the new data.
                    if (cnt == '0) begin
                        resp_data <= mem[fill_addr];
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (resp_ready) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized and directed bench for cache_mem_responder against an array-based memory model.
module tb_cache_mem_responder;
    localparam int TAG_W = 3, IDX_W = 2, DATA_W = 3, LATENCY = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_ready, req_wb = 1'b0, req_fill = 1'b0;
    logic [TAG_W-1:0] wb_tag = '0, fill_tag = '0;
    logic [IDX_W-1:0] wb_index = '0, fill_index = '0;
    logic [DATA_W-1:0] wb_data = '0, resp_data;
    logic resp_valid, resp_ready = 1'b0, busy;
    logic [7:0] wb_count, fill_count;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem_m [32];
    logic [7:0] wbc_m, fc_m;

    cache_mem_responder #(.TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_wb(req_wb), .req_fill(req_fill), .wb_tag(wb_tag), .wb_index(wb_index),
        .wb_data(wb_data), .fill_tag(fill_tag), .fill_index(fill_index),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .wb_count(wb_count), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = DATA_W'(i);
        wbc_m = 8'd0;
        fc_m  = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one request, updates the model, and returns what the DUT showed when resp_valid rose.
    task automatic issue(input logic wb, input logic fill, input logic [2:0] wt, input logic [1:0] wi,
                         input logic [2:0] wd, input logic [2:0] ft, input logic [1:0] fi, input logic rr,
                         output int lat, output logic [2:0] data, output int busy_n,
                         output int exp_lat, output logic [2:0] exp_data);
        @(negedge clk);
        req_valid = 1'b1; req_wb = wb; req_fill = fill;
        wb_tag = wt; wb_index = wi; wb_data = wd; fill_tag = ft; fill_index = fi;
        resp_ready = rr;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        // Junk on the request bus while busy must be ignored.
        req_valid = 1'($urandom); req_wb = 1'($urandom); req_fill = 1'($urandom);
        wb_tag = 3'($urandom); wb_index = 2'($urandom); wb_data = 3'($urandom);
        fill_tag = 3'($urandom); fill_index = 2'($urandom);
        if (wb) mem_m[{wt, wi}] = wd;
        exp_data = fill ? mem_m[{ft, fi}] : 3'd0;
        exp_lat  = (int'(wb) + int'(fill)) * LATENCY;
        if (wb)   wbc_m = wbc_m + 8'd1;
        if (fill) fc_m  = fc_m + 8'd1;
        lat = 0;
        busy_n = 0;
        while (!resp_valid && lat < 50) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat >= 50) begin
            errors++;
            $display("FAIL issue_timeout: resp_valid never rose within 50 cycles");
        end
        data = resp_data;
        if (busy) busy_n++;
        if (rr) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (busy) busy_n++;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_data, busy, wb_count, fill_count} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%0d busy=%b wbc=%0d fc=%0d required 1 0 0 0 0 0",
                     req_ready, resp_valid, resp_data, busy, wb_count, fill_count);
        end
        do_reset();
    endtask

    task automatic test_fill();
        int lat, bn, el;
        logic [2:0] d, ed;
        issue(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 3'b100, 2'b00, 1'b1, lat, d, bn, el, ed);
        checks++;
        if (lat !== el || d !== ed || d !== 3'b000) begin
            errors++;
            $display("FAIL fill_first: lat=%0d data=%0d required lat=%0d data=%0d", lat, d, el, ed);
        end
        checks++;
        if (fill_count !== fc_m || fill_count !== 8'd1) begin
            errors++;
            $display("FAIL fill_count_one: fill_count=%0d required %0d", fill_count, fc_m);
        end
        issue(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 3'b101, 2'b00, 1'b1, lat, d, bn, el, ed);
        checks++;
        if (lat !== el || d !== ed || d !== 3'b100) begin
            errors++;
            $display("FAIL fill_second: lat=%0d data=%0d required lat=%0d data=%0d", lat, d, el, ed);
        end
        checks++;
        if (bn !== el + 1) begin
            errors++;
            $display("FAIL fill_busy_cycles: busy cycles=%0d required %0d", bn, el + 1);
        end
    endtask

    task automatic test_wb_fill();
        int lat, bn, el;
        logic [2:0] d, ed;
        issue(1'b1, 1'b1, 3'b111, 2'b10, 3'b010, 3'b001, 2'b10, 1'b1, lat, d, bn, el, ed);
        checks++;
        if (lat !== el || d !== ed || d !== 3'b110) begin
            errors++;
            $display("FAIL wb_fill: lat=%0d data=%0d required lat=%0d data=%0d", lat, d, el, ed);
        end
        issue(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 3'b111, 2'b10, 1'b1, lat, d, bn, el, ed);
        checks++;
        if (d !== ed || d !== 3'b010) begin
            errors++;
            $display("FAIL wb_readback: data=%0d required %0d", d, ed);
        end
        checks++;
        if (wb_count !== wbc_m || wb_count !== 8'd1) begin
            errors++;
            $display("FAIL wb_count_one: wb_count=%0d required %0d", wb_count, wbc_m);
        end
    endtask

    task automatic test_same_addr();
        int lat, bn, el;
        logic [2:0] d, ed;
        issue(1'b1, 1'b1, 3'b111, 2'b10, 3'b011, 3'b111, 2'b10, 1'b1, lat, d, bn, el, ed);
        checks++;
        if (lat !== el || d !== ed || d !== 3'b011) begin
            errors++;
            $display("FAIL same_addr: lat=%0d data=%0d required lat=%0d data=%0d", lat, d, el, ed);
        end
    endtask

    task automatic test_backpressure();
        int lat, bn, el;
        logic [2:0] d, ed;
        issue(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 3'b010, 2'b11, 1'b0, lat, d, bn, el, ed);
        checks++;
        if (d !== ed) begin
            errors++;
            $display("FAIL bp_data: data=%0d required %0d", d, ed);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== ed || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b data=%0d rdy=%b required 1 %0d 0", i, resp_valid, resp_data, req_ready, ed);
            end
        end
        consume();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b required 0 1 0", resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset_mid_wb();
        int lat, bn, el;
        logic [2:0] d, ed;
        @(negedge clk);
        req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b0;
        wb_tag = 3'b000; wb_index = 2'b01; wb_data = 3'b101;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midwb_busy: busy=%b required 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_data, busy, wb_count, fill_count} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL midwb_reset: rdy=%b vld=%b data=%0d busy=%b wbc=%0d fc=%0d required 1 0 0 0 0 0",
                     req_ready, resp_valid, resp_data, busy, wb_count, fill_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        issue(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 3'b000, 2'b01, 1'b1, lat, d, bn, el, ed);
        checks++;
        if (d !== ed || d !== 3'b001) begin
            errors++;
            $display("FAIL midwb_aborted: data=%0d required %0d", d, ed);
        end
    endtask

    task automatic test_random();
        int lat, bn, el;
        logic [2:0] d, ed;
        logic rr;
        for (int n = 0; n < 40; n++) begin
            rr = 1'($urandom);
            issue(1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), 3'($urandom),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rr, lat, d, bn, el, ed);
            if (!rr) consume();
            checks++;
            if (lat !== el || d !== ed || wb_count !== wbc_m || fill_count !== fc_m) begin
                errors++;
                $display("FAIL random%0d: lat=%0d data=%0d wbc=%0d fc=%0d required lat=%0d data=%0d wbc=%0d fc=%0d",
                         n, lat, d, wb_count, fill_count, el, ed, wbc_m, fc_m);
            end
        end
    endtask

    task automatic test_fill_wrap();
        int lat, bn, el;
        logic [2:0] d, ed;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            issue(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 3'($urandom), 2'($urandom), 1'b1, lat, d, bn, el, ed);
        end
        checks++;
        if (fill_count !== fc_m || wb_count !== wbc_m) begin
            errors++;
            $display("FAIL fill_wrap: fill_count=%0d wb_count=%0d required %0d %0d", fill_count, wb_count, fc_m, wbc_m);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_wb_fill();
        test_same_addr();
        test_backpressure();
        test_reset_mid_wb();
        test_random();
        test_fill_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
